// File: rtl/multi_bank_mem_arbiter.sv
// multi_bank_mem_arbiter
// Two-requester arbiter/sequencer in front of a 2048x8 memory built from 128-entry
// sub-memories (sub-memory select = addr[ADDR_W-1:ADDR_W-4]). After reset it optionally
// clears the whole memory, then issues per cycle one read plus one write (different
// sub-memories) or a single access, and routes read data back to the issuing requester.
//
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   reqN, weN, addrN, wdataN         requester N request (held until gntN), write flag,
//                                    address, write data
//   gntN                             combinational grant, access issued at this edge
//   rvalidN, rdataN                  read return for requester N (cycle after issue)
//   init_done                        high once the clear sequence has finished
//   mem_ren/wen/raddr/waddr/din      memory command outputs
//   mem_dout                         memory read data, valid the cycle after a read
module multi_bank_mem_arbiter #(
  parameter int unsigned          ADDR_W   = 11,
  parameter int unsigned          DATA_W   = 8,
  parameter int unsigned          INIT_EN  = 1,
  parameter logic [DATA_W-1:0]    INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              gnt0,
  output logic              rvalid0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt1,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata1,
  output logic              init_done,
  output logic              mem_ren,
  output logic              mem_wen,
  output logic [ADDR_W-1:0] mem_raddr,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam int unsigned BankMsb = ADDR_W - 1;
  localparam int unsigned BankLsb = ADDR_W - 4;

  typedef enum logic {StInit, StRun} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic                init_done_q;
  logic                rr_q, rr_d;
  logic                tag_vld_q, tag_vld_d;
  logic                tag_id_q, tag_id_d;
  logic                both;
  logic                dual;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rr_d      = rr_q;
    tag_vld_d = 1'b0;
    tag_id_d  = 1'b0;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    mem_ren   = 1'b0;
    mem_wen   = 1'b0;
    mem_raddr = '0;
    mem_waddr = '0;
    mem_din   = '0;
    both      = req0 & req1;
    // Dual issue only when one reads, one writes, and they hit different sub-memories;
    // a same-sub-memory read/write would make the memory return 0.
    dual      = both && (we0 != we1) && (addr0[BankMsb:BankLsb] != addr1[BankMsb:BankLsb]);

    // Outputs are held quiet while reset is asserted.
    if (!rst) begin
      unique case (state_q)
        StInit: begin
          mem_wen   = 1'b1;
          mem_waddr = cnt_q;
          mem_din   = INIT_VAL;
          cnt_d     = cnt_q + 1'b1;
          if (cnt_q == '1) state_d = StRun;
        end
        StRun: begin
          if (dual) begin
            gnt0 = 1'b1;
            gnt1 = 1'b1;
          end else if (both) begin
            gnt0 = ~rr_q;
            gnt1 = rr_q;
            rr_d = ~rr_q;  // pointer moves to the loser
          end else begin
            gnt0 = req0;
            gnt1 = req1;
          end

          if (gnt0) begin
            if (we0) begin
              mem_wen   = 1'b1;
              mem_waddr = addr0;
              mem_din   = wdata0;
            end else begin
              mem_ren   = 1'b1;
              mem_raddr = addr0;
              tag_vld_d = 1'b1;
              tag_id_d  = 1'b0;
            end
          end
          if (gnt1) begin
            if (we1) begin
              mem_wen   = 1'b1;
              mem_waddr = addr1;
              mem_din   = wdata1;
            end else begin
              mem_ren   = 1'b1;
              mem_raddr = addr1;
              tag_vld_d = 1'b1;
              tag_id_d  = 1'b1;
            end
          end
        end
        default: state_d = StInit;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= (INIT_EN != 0) ? StInit : StRun;
      cnt_q       <= '0;
      init_done_q <= 1'b0;
      rr_q        <= 1'b0;
      tag_vld_q   <= 1'b0;
      tag_id_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      init_done_q <= (state_d == StRun);
      rr_q        <= rr_d;
      tag_vld_q   <= tag_vld_d;
      tag_id_q    <= tag_id_d;
    end
  end

  assign init_done = init_done_q;
  assign rvalid0   = tag_vld_q & ~tag_id_q;
  assign rvalid1   = tag_vld_q & tag_id_q;
  assign rdata0    = rvalid0 ? mem_dout : '0;
  assign rdata1    = rvalid1 ? mem_dout : '0;

endmodule

// File: tb/tb_multi_bank_mem_arbiter.sv
module tb_multi_bank_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, we0, req1, we1;
  logic [10:0] addr0, addr1;
  logic [7:0]  wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1, init_done;
  logic [7:0]  rdata0, rdata1;
  logic        mem_ren, mem_wen;
  logic [10:0] mem_raddr, mem_waddr;
  logic [7:0]  mem_din, mem_dout;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multi_bank_mem_arbiter dut (
    .clk(clk), .rst(rst),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
    .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
    .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
    .init_done(init_done),
    .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_raddr(mem_raddr),
    .mem_waddr(mem_waddr), .mem_din(mem_din), .mem_dout(mem_dout)
  );

  // Memory stub: registered read, sub-memory conflict returns 0.
  logic [7:0] mem [2048];
  always @(posedge clk) begin
    if (mem_ren)
      mem_dout <= (mem_wen && mem_raddr[10:7] == mem_waddr[10:7]) ? 8'h00 : mem[mem_raddr];
    if (mem_wen) mem[mem_waddr] <= mem_din;
  end

  // Reference contents as seen by the requesters.
  logic [7:0] ref_mem [2048];

  // Sampled DUT outputs from the last step.
  logic        s_g0, s_g1, s_ren, s_wen, s_rv0, s_rv1;
  logic [10:0] s_raddr, s_waddr;
  logic [7:0]  s_din, s_rd0, s_rd1;

  task automatic step(input logic r0, input logic w0, input logic [10:0] a0,
                      input logic [7:0] d0, input logic r1, input logic w1,
                      input logic [10:0] a1, input logic [7:0] d1);
    @(negedge clk);
    req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
    req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    #1;
    s_g0 = gnt0; s_g1 = gnt1; s_ren = mem_ren; s_wen = mem_wen;
    s_raddr = mem_raddr; s_waddr = mem_waddr; s_din = mem_din;
    @(posedge clk);
    #1;
    s_rv0 = rvalid0; s_rd0 = rdata0; s_rv1 = rvalid1; s_rd1 = rdata1;
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
    rst = 1'b1;
    req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
    req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({gnt0, gnt1, mem_ren, mem_wen} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctrl: got %b required 0000", {gnt0, gnt1, mem_ren, mem_wen});
    end
    checks++;
    if ({mem_raddr, mem_waddr, mem_din} !== 30'h0) begin
      failures++;
      $display("FAIL reset_bus: got %h required 0", {mem_raddr, mem_waddr, mem_din});
    end
    checks++;
    if ({init_done, rvalid0, rvalid1, rdata0, rdata1} !== 19'h0) begin
      failures++;
      $display("FAIL reset_status: got %h required 0", {init_done, rvalid0, rvalid1, rdata0, rdata1});
    end
  endtask

  // Clear sequence with a write from requester 0 held throughout.
  task automatic test_init;
    int bad = 0;
    for (int i = 0; i < 2048; i++) ref_mem[i] = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    req0 = 1; we0 = 1; addr0 = 11'h005; wdata0 = 8'hA5;
    for (int i = 0; i < 2048; i++) begin
      #1;
      if (!(mem_wen === 1'b1 && mem_ren === 1'b0 && mem_waddr === 11'(i) && mem_din === 8'h00
            && gnt0 === 1'b0 && gnt1 === 1'b0 && init_done === 1'b0)) begin
        if (bad < 4)
          $display("FAIL init_cycle: cycle %0d got wen=%b waddr=%h din=%h gnt0=%b done=%b required wen=1 waddr=%h din=00 gnt0=0 done=0",
                   i, mem_wen, mem_waddr, mem_din, gnt0, init_done, 11'(i));
        bad++;
      end
      @(negedge clk);
    end
    checks++;
    if (bad != 0) failures++;
    #1;
    checks++;
    if (init_done !== 1'b1) begin
      failures++;
      $display("FAIL init_done: got %b required 1", init_done);
    end
    checks++;
    if ({gnt0, gnt1, mem_wen, mem_waddr, mem_din} !== {1'b1, 1'b0, 1'b1, 11'h005, 8'hA5}) begin
      failures++;
      $display("FAIL held_write: got gnt=%b%b wen=%b waddr=%h din=%h required 101 005 a5",
               gnt0, gnt1, mem_wen, mem_waddr, mem_din);
    end
    @(posedge clk);
    ref_mem[11'h005] = 8'hA5;
  endtask

  task automatic test_write_read;
    step(1, 0, 11'h005, 8'h00, 0, 0, 11'h000, 8'h00);
    checks++;
    if ({s_g0, s_ren, s_raddr} !== {1'b1, 1'b1, 11'h005}) begin
      failures++;
      $display("FAIL wr_rd_issue: got g0=%b ren=%b raddr=%h required 1 1 005", s_g0, s_ren, s_raddr);
    end
    checks++;
    if ({s_rv0, s_rd0, s_rv1, s_rd1} !== {1'b1, ref_mem[11'h005], 1'b0, 8'h00}) begin
      failures++;
      $display("FAIL wr_rd_return: got rv0=%b rd0=%h rv1=%b rd1=%h required 1 %h 0 00",
               s_rv0, s_rd0, s_rv1, s_rd1, ref_mem[11'h005]);
    end
  endtask

  task automatic test_dual;
    step(1, 0, 11'h000, 8'h00, 1, 1, 11'h080, 8'h3C);
    checks++;
    if ({s_g0, s_g1, s_ren, s_wen} !== 4'b1111) begin
      failures++;
      $display("FAIL dual_grant: got %b required 1111", {s_g0, s_g1, s_ren, s_wen});
    end
    checks++;
    if ({s_raddr, s_waddr, s_din} !== {11'h000, 11'h080, 8'h3C}) begin
      failures++;
      $display("FAIL dual_bus: got raddr=%h waddr=%h din=%h required 000 080 3c", s_raddr, s_waddr, s_din);
    end
    checks++;
    if ({s_rv0, s_rd0, s_rv1} !== {1'b1, 8'h00, 1'b0}) begin
      failures++;
      $display("FAIL dual_return: got rv0=%b rd0=%h rv1=%b required 1 00 0", s_rv0, s_rd0, s_rv1);
    end
    ref_mem[11'h080] = 8'h3C;
  endtask

  task automatic test_conflict;
    step(1, 1, 11'h010, 8'h77, 1, 0, 11'h011, 8'h00);
    checks++;
    if ({s_g0, s_g1, s_wen, s_ren} !== 4'b1010) begin
      failures++;
      $display("FAIL conflict_c1: got g0g1wenren=%b required 1010", {s_g0, s_g1, s_wen, s_ren});
    end
    ref_mem[11'h010] = 8'h77;
    step(1, 1, 11'h010, 8'h77, 1, 0, 11'h011, 8'h00);
    checks++;
    if ({s_g0, s_g1, s_wen, s_ren} !== 4'b0101) begin
      failures++;
      $display("FAIL conflict_c2: got g0g1wenren=%b required 0101", {s_g0, s_g1, s_wen, s_ren});
    end
    checks++;
    if ({s_rv1, s_rd1, s_rv0} !== {1'b1, ref_mem[11'h011], 1'b0}) begin
      failures++;
      $display("FAIL conflict_return: got rv1=%b rd1=%h rv0=%b required 1 %h 0",
               s_rv1, s_rd1, s_rv0, ref_mem[11'h011]);
    end
    step(1, 1, 11'h010, 8'h77, 0, 0, 11'h000, 8'h00);
  endtask

  task automatic test_alternate;
    int bad = 0;
    for (int i = 0; i < 6; i++) begin
      logic exp0;
      exp0 = (i % 2 == 0);
      step(1, 0, 11'h005, 8'h00, 1, 0, 11'h080, 8'h00);
      if (!(s_g0 === exp0 && s_g1 === !exp0 && s_rv0 === exp0 && s_rv1 === !exp0
            && s_rd0 === (exp0 ? ref_mem[11'h005] : 8'h00)
            && s_rd1 === (exp0 ? 8'h00 : ref_mem[11'h080]))) begin
        bad++;
        $display("FAIL alternate: cycle %0d got g=%b%b rv=%b%b rd0=%h rd1=%h required g0=%b",
                 i, s_g0, s_g1, s_rv0, s_rv1, s_rd0, s_rd1, exp0);
      end
    end
    checks++;
    if (bad != 0) failures++;
  endtask

  task automatic test_random;
    logic        p0 = 0, p1 = 0, pw0 = 0, pw1 = 0, mrr = 0;
    logic [10:0] pa0 = '0, pa1 = '0;
    logic [7:0]  pd0 = '0, pd1 = '0;
    int bad_g = 0, bad_r = 0;
    for (int c = 0; c < 400; c++) begin
      logic e0, e1, erv0, erv1;
      logic [7:0] erd0, erd1;
      if (!p0 && $urandom_range(0, 9) < 7) begin
        p0 = 1; pw0 = 1'($urandom); pd0 = 8'($urandom);
        pa0 = {4'($urandom_range(0, 3)), 7'($urandom_range(0, 3))};
      end
      if (!p1 && $urandom_range(0, 9) < 7) begin
        p1 = 1; pw1 = 1'($urandom); pd1 = 8'($urandom);
        pa1 = {4'($urandom_range(0, 3)), 7'($urandom_range(0, 3))};
      end
      // Reference: compatible pair goes together, otherwise round robin; lone request wins.
      e0 = p0; e1 = p1;
      if (p0 && p1 && !(pw0 != pw1 && pa0[10:7] != pa1[10:7])) begin
        e0 = (mrr == 1'b0);
        e1 = !e0;
        mrr = e0;
      end
      erv0 = e0 && !pw0; erd0 = erv0 ? ref_mem[pa0] : 8'h00;
      erv1 = e1 && !pw1; erd1 = erv1 ? ref_mem[pa1] : 8'h00;
      step(p0, pw0, pa0, pd0, p1, pw1, pa1, pd1);
      if ({s_g0, s_g1} !== {e0, e1}) begin
        if (bad_g < 4)
          $display("FAIL rand_grant: cycle %0d got %b%b required %b%b", c, s_g0, s_g1, e0, e1);
        bad_g++;
      end
      if ({s_rv0, s_rd0, s_rv1, s_rd1} !== {erv0, erd0, erv1, erd1}) begin
        if (bad_r < 4)
          $display("FAIL rand_read: cycle %0d got rv0=%b rd0=%h rv1=%b rd1=%h required %b %h %b %h",
                   c, s_rv0, s_rd0, s_rv1, s_rd1, erv0, erd0, erv1, erd1);
        bad_r++;
      end
      if (e0 && pw0) ref_mem[pa0] = pd0;
      if (e1 && pw1) ref_mem[pa1] = pd1;
      if (e0) p0 = 0;
      if (e1) p1 = 0;
    end
    checks++;
    if (bad_g != 0) failures++;
    checks++;
    if (bad_r != 0) failures++;
  endtask

  task automatic test_reset_mid;
    step(1, 0, 11'h005, 8'h00, 0, 0, 11'h000, 8'h00);
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({rvalid0, rdata0, rvalid1, init_done} !== 11'h0) begin
      failures++;
      $display("FAIL midreset_flush: got rv0=%b rd0=%h rv1=%b done=%b required all 0",
               rvalid0, rdata0, rvalid1, init_done);
    end
    @(negedge clk);
    req0 = 0; req1 = 0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({mem_wen, mem_waddr, rvalid0, init_done} !== {1'b1, 11'h000, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL midreset_restart: got wen=%b waddr=%h rv0=%b done=%b required 1 000 0 0",
               mem_wen, mem_waddr, rvalid0, init_done);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({mem_waddr, rvalid0} !== {11'h001, 1'b0}) begin
      failures++;
      $display("FAIL midreset_count: got waddr=%h rv0=%b required 001 0", mem_waddr, rvalid0);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_write_read();
    test_dual();
    test_conflict();
    test_alternate();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multi_bank_mem_arbiter.md
Name: multi_bank_mem_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the 2048x8 multi-bank memory: one write port and one read port, registered read data, 128-entry sub-memories selected by addr[10:7].
- After reset it clears the whole memory, then grants each cycle one read plus one write, or one access only.
- Per-requester read-return tracking: a requester never sees another's data.
- A sub-memory conflict (same-cycle read and write in one sub-memory) returns 0 from the memory, so the arbiter never issues one.

Parameters:
ADDR_W, 11, memory address width (fixed by the memory; sub-memory select is addr[ADDR_W-1:ADDR_W-4])
DATA_W, 8, data width
INIT_EN, 1, 1 = run the clear sequence after reset; 0 = enter RUN directly
INIT_VAL, 8'h00, value written to every location during clear

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-high reset
req0  input  1  requester 0 request; held until gnt0
we0  input  1  requester 0: 1 = write, 0 = read
addr0  input  ADDR_W  requester 0 address
wdata0  input  DATA_W  requester 0 write data
gnt0  output  1  combinational grant; access issued at this rising edge
rvalid0  output  1  requester 0 read data valid
rdata0  output  DATA_W  requester 0 read data
req1, we1, addr1, wdata1, gnt1, rvalid1, rdata1  (same as requester 0, for requester 1)
init_done  output  1  high once clear is finished
mem_ren  output  1  to memory ren
mem_wen  output  1  to memory wen
mem_raddr  output  ADDR_W  to memory raddr
mem_waddr  output  ADDR_W  to memory waddr
mem_din  output  DATA_W  to memory din
mem_dout  input  DATA_W  from memory dout, valid the cycle after a read is issued

Behaviour:
- Reset values: state = INIT (RUN if INIT_EN=0), clear counter = 0, init_done = 0, rr_ptr = 0, rvalid0/1 = 0, pending-read tag cleared.
- Reset values continued: gnt0/1 = 0, mem_ren = mem_wen = 0, mem_* addresses and din = 0, rdata0/1 = 0.
- INIT state:
  - Each cycle: mem_wen = 1, mem_waddr = counter, mem_din = INIT_VAL, mem_ren = 0, no grants.
  - Counter increments 0..2047; in the cycle it holds 2047, next state = RUN.
  - init_done registered high from the first RUN cycle onward; takes exactly 2048 cycles.
- RUN state, grant decision (combinational, per cycle):
  - Only req0: grant 0. Only req1: grant 1.
  - Both, one read + one write, different sub-memory (addr[10:7] differ): grant both, the read on mem_r*, the write on mem_w*.
  - Otherwise (both reads, both writes, or same sub-memory): grant only the requester selected by rr_ptr (0 -> req0, 1 -> req1).
- rr_ptr update: after a single grant while both requested, rr_ptr = index of the loser. Unchanged on a dual grant or an uncontested grant.
- Port driving:
  - Granted write: mem_wen = 1, mem_waddr/mem_din from that requester.
  - Granted read: mem_ren = 1, mem_raddr from that requester.
  - Ungranted port: enable 0, address/data 0.
- Read return:
  - Read issued at edge T: tag register records the requester.
  - In cycle T+1, rvalidN = 1 and rdataN = mem_dout for the tagged requester only. rvalid/rdata of the other requester stay 0; rdata = 0 whenever rvalid = 0.
  - Back-to-back reads: one rvalid per cycle, in issue order.
- Requests during INIT are held, not granted, not dropped.
- Same-address write then read in the next cycle returns the new data; same-cycle same-address is serialized by the conflict rule.
- Reset mid-operation: INIT restarts from address 0, init_done drops, any pending rvalid is discarded (no pulse after reset).

Test Plan:
- Reset, INIT_EN=1 -> 2048 consecutive mem_wen pulses, waddr 0..2047, din 0x00; init_done high in cycle 2049; a req0 held during INIT is granted only in the first RUN cycle.
- req0 write addr 0x005 data 0xA5, then next cycle req0 read addr 0x005 -> rvalid0 one cycle after grant, rdata0 = 0xA5, rvalid1 = 0.
- Same cycle: req0 read 0x000, req1 write 0x080 = 0x3C (sub-memories 0 and 1) -> gnt0 = gnt1 = 1, mem_ren = mem_wen = 1; next cycle rdata0 = 0x00.
- Same cycle: req0 write 0x010, req1 read 0x011 (same sub-memory), held 2 cycles -> cycle 1 gnt0 only (rr_ptr = 0), cycle 2 gnt1 only; rdata1 equals the value just written by req0 only if the addresses are equal, else 0x00.
- Both requesters hold reads for 6 cycles -> grants alternate 0,1,0,1,0,1; each rvalid matches its own address contents.
- Assert rst for 1 cycle while a read is in flight (issued the previous cycle) -> no rvalid pulse, init_done = 0, INIT restarts at waddr 0.
